// File: rtl/mult_arb_pkg.sv
// ============================================================================
// Module   : mult_arb_pkg
// Purpose  : Shared types and constants for the mult_arb multiplier sequencer:
//            FSM state encoding, default coefficient, index-width helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] COEF_INIT_DEFAULT = 8'b01010101;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mult_arb_if.sv
// ============================================================================
// Module   : mult_arb_if
// Purpose  : Request/grant/result bundle between the filter-stage requesters
//            and the shared multiplier. The coefficient write port is present
//            only when MULT_ARB_COEF_WR_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_arb_if
  import mult_arb_pkg::*;
#(
  parameter int N    = 8,
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
);

  logic [NREQ-1:0]   req;
  logic [NREQ*N-1:0] op_data;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic              res_ready;
  logic [IW-1:0]     res_id;
  logic [2*N-1:0]    res_data;

`ifdef MULT_ARB_COEF_WR_EN
  logic              coef_we;
  logic [IW-1:0]     coef_addr;
  logic [N-1:0]      coef_wdata;

  modport slave (
    input  req, op_data, res_ready, coef_we, coef_addr, coef_wdata,
    output gnt, res_valid, res_id, res_data
  );

  modport master (
    output req, op_data, res_ready, coef_we, coef_addr, coef_wdata,
    input  gnt, res_valid, res_id, res_data
  );
`else
  modport slave (
    input  req, op_data, res_ready,
    output gnt, res_valid, res_id, res_data
  );

  modport master (
    output req, op_data, res_ready,
    input  gnt, res_valid, res_id, res_data
  );
`endif

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Searches the request vector
//            starting at ptr and wrapping; reports one-hot winner, its index
//            and whether any request was present. Pointer storage is external.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import mult_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            any
);

  // First requester at or after ptr wins; index arithmetic wraps naturally
  // because NREQ is a power of two.
  always_comb begin
    logic [IW-1:0] cand;
    cand  = '0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      cand = ptr + IW'(k);
      if (!any && req[cand]) begin
        any         = 1'b1;
        idx         = cand;
        grant[cand] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mult_arb.sv
// ============================================================================
// Module   : mult_arb
// Purpose  : Round-robin sequencer sharing one registered constant-coefficient
//            multiplier among NREQ requesters. Result returned with requester
//            id over a valid/ready handshake. One result per 3 cycles at most.
//            Define MULT_ARB_COEF_WR_EN to make the coefficient table writable;
//            otherwise every coefficient is the constant COEF_INIT.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_arb
  import mult_arb_pkg::*;
#(
  parameter int             N         = 8,
  parameter int             NREQ      = 4,
  parameter logic [N-1:0]   COEF_INIT = N'(COEF_INIT_DEFAULT)
) (
  input  logic      clk,
  input  logic      rst,
  mult_arb_if.slave bus
);

  localparam int IW = idx_width(NREQ);

  state_t          state,     state_n;
  logic [IW-1:0]   ptr,       ptr_n;
  logic [NREQ-1:0] gnt_q,     gnt_n;
  logic            valid_q,   valid_n;
  logic [IW-1:0]   id_q,      id_n;
  logic [2*N-1:0]  data_q,    data_n;
  logic [N-1:0]    op_q,      op_n;
  logic [N-1:0]    mult_coef;
  logic [2*N-1:0]  product;

  logic [NREQ-1:0] win_onehot;
  logic [IW-1:0]   win_idx;
  logic            win_any;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr (
    .req   (bus.req),
    .ptr   (ptr),
    .grant (win_onehot),
    .idx   (win_idx),
    .any   (win_any)
  );

`ifdef MULT_ARB_COEF_WR_EN
  logic [N-1:0] coef [NREQ];
  logic [N-1:0] coef_q, coef_n;

  // Coefficient table, writable in any FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) coef[i] <= COEF_INIT;
    end else if (bus.coef_we) begin
      coef[bus.coef_addr] <= bus.coef_wdata;
    end
  end

  assign mult_coef = coef_q;
`else
  assign mult_coef = COEF_INIT;
`endif

  assign product = (2*N)'(op_q) * (2*N)'(mult_coef);

  // Next-state and next-output decode; every register holds by default.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = '0;
    valid_n = valid_q;
    id_n    = id_q;
    data_n  = data_q;
    op_n    = op_q;
`ifdef MULT_ARB_COEF_WR_EN
    coef_n  = coef_q;
`endif
    case (state)
      IDLE: begin
        if (win_any) begin
          state_n = MUL;
          gnt_n   = win_onehot;
          id_n    = win_idx;
          op_n    = bus.op_data[int'(win_idx)*N +: N];
          ptr_n   = win_idx + IW'(1);
`ifdef MULT_ARB_COEF_WR_EN
          // Table read sees the pre-write value on a same-edge write.
          coef_n  = coef[win_idx];
`endif
        end
      end
      MUL: begin
        state_n = DONE;
        data_n  = product;
        valid_n = 1'b1;
      end
      DONE: begin
        if (bus.res_ready) begin
          state_n = IDLE;
          valid_n = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        valid_n = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      id_q    <= '0;
      data_q  <= '0;
      op_q    <= '0;
`ifdef MULT_ARB_COEF_WR_EN
      coef_q  <= COEF_INIT;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      gnt_q   <= gnt_n;
      valid_q <= valid_n;
      id_q    <= id_n;
      data_q  <= data_n;
      op_q    <= op_n;
`ifdef MULT_ARB_COEF_WR_EN
      coef_q  <= coef_n;
`endif
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.res_valid = valid_q;
  assign bus.res_id    = id_q;
  assign bus.res_data  = data_q;

endmodule

`default_nettype wire

// File: tb/tb_mult_arb.sv
// ============================================================================
// Module   : tb_mult_arb
// Purpose  : Self-checking bench for mult_arb. Requesters and the expected
//            grant order/products come from a transaction-level model
//            (pending set, round-robin start index, coefficient table).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_arb;

  localparam int N    = 8;
  localparam int NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [N-1:0]    ops [NREQ];
  logic [N-1:0]    mc  [NREQ];
  logic [NREQ-1:0] pend;
  int              ptr;

  mult_arb_if #(.N(N), .NREQ(NREQ)) bus ();

  mult_arb #(.N(N), .NREQ(NREQ)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive;
    bus.req = pend;
    for (int i = 0; i < NREQ; i++) bus.op_data[i*N +: N] = ops[i];
  endtask

  task automatic pulse_reset;
    @(negedge clk);
    rst  = 1'b1;
    pend = '0;
    drive();
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr = 0;
  endtask

  // Round-robin rule: first pending requester at or after start, wrapping.
  function automatic int rr_pick(input logic [NREQ-1:0] p, input int start);
    for (int k = 0; k < NREQ; k++)
      if (p[(start + k) % NREQ]) return (start + k) % NREQ;
    return -1;
  endfunction

  task automatic test_reset;
    pend = '0;
    for (int i = 0; i < NREQ; i++) begin ops[i] = '0; mc[i] = 8'h55; end
    drive();
    bus.res_ready = 1'b1;
`ifdef MULT_ARB_COEF_WR_EN
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_wdata = '0;
`endif
    ptr = 0;
    #12;
    checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt); end
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.res_valid); end
    checks++; if (bus.res_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", bus.res_id); end
    checks++; if (bus.res_data !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.res_data); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    checks++; if (bus.gnt !== 4'b0000 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL idle_quiet: gnt %b valid %b want 0000/0", bus.gnt, bus.res_valid); end
  endtask

  task automatic test_basic;
    pend = 4'b0001; ops[0] = 8'h02; drive();
    tick();
    checks++; if (bus.gnt !== 4'b0001 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic_gnt0: gnt %b valid %b want 0001/0", bus.gnt, bus.res_valid); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h00AA || bus.res_id !== 2'd0 || bus.gnt !== 4'b0000)
      begin errors++; $display("FAIL basic_res0: valid %b data %h id %0d gnt %b want 1/00aa/0/0000", bus.res_valid, bus.res_data, bus.res_id, bus.gnt); end
    pend = 4'b0000; drive();
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic_ack0: valid %b want 0", bus.res_valid); end
    pend = 4'b0010; ops[1] = 8'hFF; drive();
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL basic_gnt1: gnt %b want 0010", bus.gnt); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h54AB || bus.res_id !== 2'd1)
      begin errors++; $display("FAIL basic_res1: valid %b data %h id %0d want 1/54ab/1", bus.res_valid, bus.res_data, bus.res_id); end
    pend = 4'b0000; drive();
    tick();
    checks++; if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL basic_ack1: valid %b want 0", bus.res_valid); end
    ptr = 2;
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [15:0] expd;
    pulse_reset();
    for (int i = 0; i < NREQ; i++) ops[i] = N'($urandom_range(0, 255));
    pend = 4'b1111; drive();
    for (int k = 0; k < 5; k++) begin
      expd = 16'(ops[order[k]]) * 16'(mc[order[k]]);
      tick();
      checks++; if (bus.gnt !== NREQ'(1) << order[k]) begin errors++; $display("FAIL rr_gnt%0d: gnt %b want one-hot %0d", k, bus.gnt, order[k]); end
      tick();
      checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(order[k]) || bus.res_data !== expd)
        begin errors++; $display("FAIL rr_res%0d: valid %b id %0d data %h want 1/%0d/%h", k, bus.res_valid, bus.res_id, bus.res_data, order[k], expd); end
      tick();
      checks++; if (bus.res_valid !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL rr_gap%0d: valid %b gnt %b want 0/0000", k, bus.res_valid, bus.gnt); end
    end
    pend = '0; drive();
    ptr = 1;
  endtask

  task automatic test_backpressure;
    logic [15:0] exp1;
    ops[1] = N'($urandom_range(0, 255));
    exp1 = 16'(ops[1]) * 16'(mc[1]);
    pend = 4'b0010; drive();
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL bp_gnt1: gnt %b want 0010", bus.gnt); end
    pend[2] = 1'b1; ops[2] = 8'h07; bus.res_ready = 1'b0; drive();
    tick();
    pend[1] = 1'b0; drive();
    for (int s = 0; s < 6; s++) begin
      checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp1 || bus.res_id !== 2'd1 || bus.gnt !== 4'b0000)
        begin errors++; $display("FAIL bp_hold%0d: valid %b data %h id %0d gnt %b want 1/%h/1/0000", s, bus.res_valid, bus.res_data, bus.res_id, bus.gnt, exp1); end
      if (s < 5) tick();
    end
    bus.res_ready = 1'b1;
    tick();
    checks++; if (bus.res_valid !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL bp_idle: valid %b gnt %b want 0/0000", bus.res_valid, bus.gnt); end
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL bp_gnt2: gnt %b want 0100", bus.gnt); end
    tick();
    checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 16'h0253 || bus.res_id !== 2'd2)
      begin errors++; $display("FAIL bp_res2: valid %b data %h id %0d want 1/0253/2", bus.res_valid, bus.res_data, bus.res_id); end
    pend = '0; drive();
    tick();
    ptr = 3;
  endtask

  task automatic test_reset_midflight;
    logic [15:0] expd;
    ops[1] = N'($urandom_range(0, 255));
    pend = 4'b0010; drive();
    tick();
    checks++; if (bus.gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt: gnt %b want 0010", bus.gnt); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.gnt !== 4'b0000 || bus.res_valid !== 1'b0 || bus.res_id !== 2'd0 || bus.res_data !== 16'h0000)
      begin errors++; $display("FAIL mid_async: gnt %b valid %b id %0d data %h want all zero", bus.gnt, bus.res_valid, bus.res_id, bus.res_data); end
    pend = '0; drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ptr = 0;
    for (int s = 0; s < 3; s++) begin
      tick();
      checks++; if (bus.res_valid !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL mid_discard%0d: valid %b gnt %b want 0/0000", s, bus.res_valid, bus.gnt); end
    end
    ops[0] = N'($urandom_range(0, 255));
    ops[3] = N'($urandom_range(0, 255));
    pend = 4'b1001; drive();
    for (int t = 0; t < 2; t++) begin
      int w;
      w = rr_pick(pend, ptr);
      expd = 16'(ops[w]) * 16'(mc[w]);
      tick();
      checks++; if (bus.gnt !== NREQ'(1) << w) begin errors++; $display("FAIL mid_order%0d: gnt %b want one-hot %0d", t, bus.gnt, w); end
      tick();
      checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(w) || bus.res_data !== expd)
        begin errors++; $display("FAIL mid_res%0d: valid %b id %0d data %h want 1/%0d/%h", t, bus.res_valid, bus.res_id, bus.res_data, w, expd); end
      pend[w] = 1'b0; drive();
      tick();
      ptr = (w + 1) % NREQ;
    end
  endtask

`ifdef MULT_ARB_COEF_WR_EN
  task automatic test_coef;
    bus.coef_we = 1'b1; bus.coef_addr = 2'd2; bus.coef_wdata = 8'h03;
    tick();
    bus.coef_we = 1'b0;
    mc[2] = 8'h03;
    pend = 4'b0100; ops[2] = 8'h10; drive();
    tick();
    checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL coef_gnt: gnt %b want 0100", bus.gnt); end
    tick();
    checks++; if (bus.res_data !== 16'h0030) begin errors++; $display("FAIL coef_write: data %h want 0030", bus.res_data); end
    pend = '0; drive();
    tick();
    // Request and table write land on the same edge: old coefficient wins.
    pend = 4'b0100; drive();
    bus.coef_we = 1'b1; bus.coef_wdata = 8'h09;
    tick();
    bus.coef_we = 1'b0;
    tick();
    checks++; if (bus.res_data !== 16'h0030) begin errors++; $display("FAIL coef_same_edge: data %h want 0030", bus.res_data); end
    mc[2] = 8'h09;
    pend = '0; drive();
    tick();
    pend = 4'b0100; drive();
    tick();
    tick();
    checks++; if (bus.res_data !== 16'h0090) begin errors++; $display("FAIL coef_new: data %h want 0090", bus.res_data); end
    pend = '0; drive();
    tick();
    ptr = 3;
  endtask
`endif

  task automatic test_random;
    int          w;
    int          stall;
    logic [15:0] expd;
    pulse_reset();
    for (int it = 0; it < 80; it++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] && $urandom_range(0, 7) == 0) pend[i] = 1'b0;
        else if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          ops[i]  = N'($urandom_range(0, 255));
        end
      end
      drive();
      w = rr_pick(pend, ptr);
      tick();
      if (w < 0) begin
        checks++; if (bus.gnt !== 4'b0000 || bus.res_valid !== 1'b0) begin errors++; $display("FAIL rnd_idle%0d: gnt %b valid %b want 0000/0", it, bus.gnt, bus.res_valid); end
      end else begin
        expd = 16'(ops[w]) * 16'(mc[w]);
        checks++; if (bus.gnt !== NREQ'(1) << w) begin errors++; $display("FAIL rnd_gnt%0d: gnt %b want one-hot %0d", it, bus.gnt, w); end
        stall = $urandom_range(0, 3);
        bus.res_ready = (stall == 0);
        tick();
        checks++; if (bus.res_valid !== 1'b1 || bus.res_id !== 2'(w) || bus.res_data !== expd || bus.gnt !== 4'b0000)
          begin errors++; $display("FAIL rnd_res%0d: valid %b id %0d data %h gnt %b want 1/%0d/%h/0000", it, bus.res_valid, bus.res_id, bus.res_data, bus.gnt, w, expd); end
        pend[w] = 1'b0; drive();
        for (int s = 0; s < stall; s++) begin
          tick();
          checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== expd || bus.gnt !== 4'b0000)
            begin errors++; $display("FAIL rnd_stall%0d: valid %b data %h gnt %b want 1/%h/0000", it, bus.res_valid, bus.res_data, bus.gnt, expd); end
        end
        bus.res_ready = 1'b1;
        tick();
        checks++; if (bus.res_valid !== 1'b0 || bus.gnt !== 4'b0000) begin errors++; $display("FAIL rnd_ack%0d: valid %b gnt %b want 0/0000", it, bus.res_valid, bus.gnt); end
        ptr = (w + 1) % NREQ;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
`ifdef MULT_ARB_COEF_WR_EN
    test_coef();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mult_arb.md
# mult_arb

Round-robin arbiter and sequencer that shares one registered unsigned constant-coefficient multiplier among NREQ requesters in the filter datapath. Each requester presents an operand and a request. The block grants one requester at a time, multiplies its operand by that requester's coefficient, and returns the full-width product tagged with the requester index through a valid/ready handshake. It sits between the per-channel filter stages (the yk producers) and the downstream pk consumers. It replaces one multiplier per channel.

## Interface
Parameters:
- N, 8, operand and coefficient width
- NREQ, 4, number of requesters (power of two, ≥2)
- COEF_INIT, 8'b01010101, reset value of every coefficient entry

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req  in  NREQ  per-requester request, level; held until matching gnt seen
- op_data  in  NREQ*N  packed operands, requester i at [i*N +: N]; held stable while req[i]=1
- gnt  out  NREQ  one-hot grant pulse, one cycle
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_id  out  $clog2(NREQ)  index of granted requester
- res_data  out  2N  unsigned product, exact
- coef_we, coef_addr[$clog2(NREQ)], coef_wdata[N]  in  coefficient write port (only with MULT_ARB_COEF_WR_EN)

## Operation
- FSM states: IDLE, MUL, DONE.
- IDLE, no req: stay in IDLE.
- IDLE, any req: the round-robin picks a winner. At this edge, latch op_data[winner], coef[winner] and id, then go to MUL.
- MUL: gnt[id]=1 for this cycle only. res_data <= op*coef at the edge, then go to DONE.
- DONE: res_valid=1. res_data and res_id are held stable. When res_ready=1 at an edge, go to IDLE.
- Round-robin search starts at (last_granted+1) mod NREQ. After reset the pointer is 0, so req[0] has highest priority.
- The pointer updates only on a grant.
- Arithmetic is unsigned N×N→2N with no truncation and no saturation.
- Coefficient writes change only the coef table.
  - An in-flight operation uses its latched coefficient.
  - A write to coef[i] on the same edge as a grant to i: the old value is used for that operation.
- req deasserted before grant: the request is simply not serviced. There is no error.
- Requesters deassert req on the cycle after they see gnt. The FSM does not sample req again until it returns to IDLE.

## Timing
- Reset values:
  - state=IDLE
  - gnt=0
  - res_valid=0
  - res_id=0
  - res_data=0
  - RR pointer=0
  - all coef=COEF_INIT
- rst asserted in any state: all outputs reach their reset values asynchronously. Any in-flight result is discarded and no res_valid is produced.
- Latency, request seen in IDLE at edge E:
  - gnt high during the cycle after E
  - res_valid high from the cycle after E+1
- Throughput with res_ready=1: one result per 3 cycles.
- res_ready low: DONE holds indefinitely. No new gnt is issued and pending requests wait.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- MULT_ARB_COEF_WR_EN defined:
  - The coef_we/coef_addr/coef_wdata ports exist.
  - coef[coef_addr] <= coef_wdata on any edge with coef_we=1, in any state.
- Not defined:
  - Those ports are absent.
  - All coefficients are the constant COEF_INIT, and no coefficient registers are synthesized.

## Structure
- Package mult_arb_pkg:
  - FSM state encoding (IDLE=0, MUL=1, DONE=2)
  - default COEF_INIT
  - $clog2-based index width helper
- Sub-module rr_arbiter:
  - inputs: NREQ request vector, pointer
  - outputs: one-hot winner, encoded index, any-flag
  - purely combinational
  - the pointer register lives in mult_arb

## Test plan
- Reset, then req[0]=1 with op 0x02 and default coef → gnt[0] pulse on cycle 1; res_valid on cycle 2 with res_data=0x00AA, res_id=0.
- req[1] with op 0xFF → res_data=0x54AB, res_id=1. The product is exact with no truncation.
- All four req held, res_ready=1 → grants in order 0,1,2,3,0, one every 3 cycles. Each res_id matches its grant.
- res_ready=0 for 5 cycles in DONE with req[2] pending → res_valid and res_data stay stable and no gnt is issued. After res_ready=1, gnt[2] follows 1 cycle after the return to IDLE.
- rst pulsed during MUL → res_valid never asserts. After release, req[3] and req[0] pending together → req[0] granted first (pointer back to 0).
- With MULT_ARB_COEF_WR_EN: write coef[2]=0x03, then req[2] op 0x10 → res_data=0x0030.
- With MULT_ARB_COEF_WR_EN: a write to coef[2] on the grant edge → the old coefficient is used.
